// File: rtl/matrix_addsub_seq.sv
// Element-wise signed A+B / A-B over two NxN matrices, LANES elements per beat.
// Latency BEATS+1 edges from start to done; start ignored while busy.
module matrix_addsub_seq #(
   parameter int DW    = 8,
   parameter int N     = 5,
   parameter int LANES = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op,
   input  logic              sat_en,
   input  logic [N*N*DW-1:0] matrix_A,
   input  logic [N*N*DW-1:0] matrix_B,
   output logic              busy,
   output logic              done,
   output logic [N*N*DW-1:0] result_out,
   output logic [N*N-1:0]    ovf_mask,
   output logic              overflow
);
   localparam int NE    = N * N;
   localparam int BEATS = NE / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

   if ((NE % LANES) != 0) begin : g_lanes_check
      $error("LANES must divide N*N");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    beat_q;
   logic [NE*DW-1:0] a_q, b_q;
   logic             op_q, sat_q;
   logic             last_beat;

   logic [DW-1:0]    lane_a   [LANES];
   logic [DW-1:0]    lane_b   [LANES];
   logic [DW:0]      lane_sum [LANES];
   logic [DW-1:0]    lane_res [LANES];
   logic [LANES-1:0] lane_ovf;

   assign last_beat = (beat_q == CW'(BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_beat) state_d = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sign bits of the DW+1 result disagree exactly when the operand-sign overflow rule fires.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_a[l]   = a_q[(int'(beat_q) * LANES + l) * DW +: DW];
         lane_b[l]   = b_q[(int'(beat_q) * LANES + l) * DW +: DW];
         lane_sum[l] = op_q ? ({lane_a[l][DW-1], lane_a[l]} - {lane_b[l][DW-1], lane_b[l]})
                            : ({lane_a[l][DW-1], lane_a[l]} + {lane_b[l][DW-1], lane_b[l]});
         lane_ovf[l] = lane_sum[l][DW] ^ lane_sum[l][DW-1];
         if (lane_ovf[l] && sat_q) lane_res[l] = lane_a[l][DW-1] ? SAT_MIN : SAT_MAX;
         else                      lane_res[l] = lane_sum[l][DW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= 1'b0;
         sat_q      <= 1'b0;
         beat_q     <= '0;
         result_out <= '0;
         ovf_mask   <= '0;
         overflow   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q        <= matrix_A;
                  b_q        <= matrix_B;
                  op_q       <= op;
                  sat_q      <= sat_en;
                  beat_q     <= '0;
                  result_out <= '0;
                  ovf_mask   <= '0;
                  overflow   <= 1'b0;
               end
            end
            RUN: begin
               for (int l = 0; l < LANES; l++) begin
                  result_out[(int'(beat_q) * LANES + l) * DW +: DW] <= lane_res[l];
                  ovf_mask[int'(beat_q) * LANES + l]                 <= lane_ovf[l];
               end
               // Mask is cleared at start, so OR-accumulating keeps overflow == |ovf_mask.
               overflow <= overflow | (|lane_ovf);
               beat_q   <= beat_q + CW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Bench for matrix_addsub_seq: integer-arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_matrix_addsub_seq;
   localparam int DW    = 8;
   localparam int N     = 5;
   localparam int LANES = 5;
   localparam int NE    = N * N;
   localparam int BEATS = NE / LANES;
   localparam int MW    = NE * DW;
   localparam int MAXV  = (1 << (DW - 1)) - 1;
   localparam int MINV  = -(1 << (DW - 1));

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start = 1'b0;
   logic          op = 1'b0;
   logic          sat_en = 1'b0;
   logic [MW-1:0] matrix_A = '0;
   logic [MW-1:0] matrix_B = '0;
   logic          busy, done, overflow;
   logic [MW-1:0] result_out;
   logic [NE-1:0] ovf_mask;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   matrix_addsub_seq #(.DW(DW), .N(N), .LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sat_en(sat_en),
      .matrix_A(matrix_A), .matrix_B(matrix_B), .busy(busy), .done(done),
      .result_out(result_out), .ovf_mask(ovf_mask), .overflow(overflow)
   );

   task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference element: plain integer arithmetic, then range test.
   function automatic void elem(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic o, input logic s,
                                output logic [DW-1:0] v, output logic ov);
      int ia, ib, r;
      ia = int'($signed(a));
      ib = int'($signed(b));
      r  = o ? ia - ib : ia + ib;
      ov = (r > MAXV) || (r < MINV);
      if (ov && s) v = (r > MAXV) ? DW'(MAXV) : DW'(MINV);
      else         v = DW'(r);
   endfunction

   // Model: m_k counts edges since the accepted start (-1 = idle).
   int            m_k = -1;
   logic [MW-1:0] m_a = '0, m_b = '0;
   logic          m_op = 1'b0, m_sat = 1'b0;
   logic [MW-1:0] exp_res = '0;
   logic [NE-1:0] exp_mask = '0;
   logic          exp_ovf = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_k = -1; m_a = '0; m_b = '0; m_op = 1'b0; m_sat = 1'b0;
         exp_res = '0; exp_mask = '0; exp_ovf = 1'b0;
      end else if (m_k < 0) begin
         if (start) begin
            m_k = 0; m_a = matrix_A; m_b = matrix_B; m_op = op; m_sat = sat_en;
            exp_res = '0; exp_mask = '0; exp_ovf = 1'b0;
         end
      end else begin
         m_k++;
         if (m_k <= BEATS) begin
            for (int l = 0; l < LANES; l++) begin
               int e;
               logic [DW-1:0] v;
               logic ov;
               e = (m_k - 1) * LANES + l;
               elem(m_a[e*DW +: DW], m_b[e*DW +: DW], m_op, m_sat, v, ov);
               exp_res[e*DW +: DW] = v;
               exp_mask[e] = ov;
               exp_ovf = exp_ovf | ov;
            end
         end
         if (m_k == BEATS + 1) m_k = -1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_busy", MW'(busy), MW'(m_k >= 0));
         check("m_done", MW'(done), MW'(m_k == BEATS));
         check("m_result", result_out, exp_res);
         check("m_mask", MW'(ovf_mask), MW'(exp_mask));
         check("m_overflow", MW'(overflow), MW'(exp_ovf));
      end
   end

   // Call at #1 after an edge with the DUT idle; returns at #1 after the accept edge E0.
   task automatic go(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic o, input logic s);
      matrix_A = a; matrix_B = b; op = o; sat_en = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic finish_op();
      repeat (BEATS + 1) @(posedge clk);
      #1;
   endtask

   logic [MW-1:0] va, vb, vexp;

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", MW'(busy), '0);
      check("rst_done", MW'(done), '0);
      check("rst_result", result_out, '0);
      check("rst_mask", MW'(ovf_mask), '0);
      check("rst_overflow", MW'(overflow), '0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;

      // 3 + 4 everywhere; done only between E5 and E6, busy through E6.
      for (int e = 0; e < NE; e++) begin
         va[e*DW +: DW] = 8'd3; vb[e*DW +: DW] = 8'd4; vexp[e*DW +: DW] = 8'h07;
      end
      go(va, vb, 1'b0, 1'b0);
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         check("add_done_timing", MW'(done), MW'(i == 5));
         check("add_busy_timing", MW'(busy), MW'(i <= 5));
      end
      check("add_result", result_out, vexp);
      check("add_mask", MW'(ovf_mask), '0);
      check("add_overflow", MW'(overflow), '0);

      // -128 - 1 wraps to 0x7F; group 0 lands at E1.
      va = '0; vb = '0; va[7:0] = 8'h80; vb[7:0] = 8'h01;
      go(va, vb, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("subw_elem0_at_E1", MW'(result_out[7:0]), MW'(8'h7F));
      repeat (BEATS) @(posedge clk);
      #1;
      vexp = '0; vexp[7:0] = 8'h7F;
      check("subw_result", result_out, vexp);
      check("subw_mask", MW'(ovf_mask), MW'(25'h0000001));
      check("subw_overflow", MW'(overflow), MW'(1'b1));

      go(va, vb, 1'b1, 1'b1);
      finish_op();
      vexp = '0; vexp[7:0] = 8'h80;
      check("subs_result", result_out, vexp);
      check("subs_mask", MW'(ovf_mask), MW'(25'h0000001));

      // Last group: 100+100 -> 0x7F, -100+-100 -> 0x80, both written at E5.
      va = '0; vb = '0;
      va[24*DW +: DW] = 8'd100; vb[24*DW +: DW] = 8'd100;
      va[23*DW +: DW] = 8'h9C;  vb[23*DW +: DW] = 8'h9C;
      go(va, vb, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("adds_e24_before_E5", MW'(result_out[24*DW +: DW]), '0);
      @(posedge clk); #1;
      check("adds_e24_at_E5", MW'(result_out[24*DW +: DW]), MW'(8'h7F));
      check("adds_e23_at_E5", MW'(result_out[23*DW +: DW]), MW'(8'h80));
      check("adds_mask_at_E5", MW'(ovf_mask), MW'(25'h1800000));
      @(posedge clk); #1;

      // Second start at E2 with other operands must be ignored: 10+20 = 0x1E.
      for (int e = 0; e < NE; e++) begin
         va[e*DW +: DW] = 8'd10; vb[e*DW +: DW] = 8'd20; vexp[e*DW +: DW] = 8'h1E;
      end
      go(va, vb, 1'b0, 1'b0);
      @(posedge clk); #1;
      matrix_A = '1; matrix_B = '1; op = 1'b1; sat_en = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("ignore_result", result_out, vexp);
      check("ignore_busy_after", MW'(busy), '0);

      // start held high: idle after E6, re-accepted at E7.
      va = '0; vb = '0;
      matrix_A = va; matrix_B = vb; op = 1'b0; sat_en = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         check("held_busy", MW'(busy), MW'(i != 6));
      end
      start = 1'b0;
      repeat (BEATS) @(posedge clk);
      #1;

      // Reset at E3 aborts: outputs clear immediately, no done afterwards.
      for (int e = 0; e < NE; e++) begin
         va[e*DW +: DW] = 8'd50; vb[e*DW +: DW] = 8'd60;
      end
      go(va, vb, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", MW'(busy), '0);
      check("abort_done", MW'(done), '0);
      check("abort_result", result_out, '0);
      check("abort_mask", MW'(ovf_mask), '0);
      check("abort_overflow", MW'(overflow), '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("abort_no_done", MW'(done), '0);
      end

      // Fresh operations after reset, checked by the model only.
      for (int t = 0; t < 6; t++) begin
         for (int e = 0; e < NE; e++) begin
            va[e*DW +: DW] = DW'($urandom);
            vb[e*DW +: DW] = DW'($urandom);
         end
         go(va, vb, t[0], t[1]);
         finish_op();
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/matrix_addsub_seq.md
MATRIX_ADDSUB_SEQ -- requirements
Module: matrix_addsub_seq

Interface
REQ-001 SHALL have parameter DW, default 8: signed element width in bits, two's complement.
REQ-002 SHALL have parameter N, default 5: matrix dimension; N*N elements per matrix, element i at bits [i*DW +: DW].
REQ-003 SHALL have parameter LANES, default 5: elements processed per cycle; LANES divides N*N (elaboration error otherwise); BEATS = N*N/LANES.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 op  input  1  0 = A+B, 1 = A-B; latched at start.
REQ-008 sat_en  input  1  1 = saturate on overflow, 0 = wrap; latched at start.
REQ-009 matrix_A  input  N*N*DW  operand A; latched at start.
REQ-010 matrix_B  input  N*N*DW  operand B; latched at start.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 result_out  output  N*N*DW  element-wise result, registered.
REQ-014 ovf_mask  output  N*N  per-element overflow flag, registered.
REQ-015 overflow  output  1  OR of ovf_mask, registered.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE with start=1 at an edge SHALL latch A, B, op, sat_en, clear result_out, ovf_mask and overflow to 0, zero the beat counter, and enter RUN.
REQ-018 RUN SHALL compute one group per edge, elements g*LANES to g*LANES+LANES-1, with g = beat counter, and write only those result and mask bits.
REQ-019 RUN SHALL increment the beat counter each edge and enter DONE on the edge that writes group BEATS-1.
REQ-020 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-021 Latency: with start accepted at edge E0, group g SHALL be written at edge E(g+1), done SHALL be high between E(BEATS) and E(BEATS+1), and busy SHALL be high from E0 through E(BEATS+1).
REQ-022 Defaults give 5 RUN beats; done SHALL be high in the 6th cycle after the start edge.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the latched operands or outputs.
REQ-024 start held high continuously SHALL be re-accepted on the edge in IDLE after DONE.
REQ-025 Arithmetic SHALL compute a DW+1-bit sign-extended sum or difference; the raw result is its low DW bits.
REQ-026 Add overflow SHALL be flagged when a and b have equal signs and raw sign differs from a.
REQ-027 Sub overflow SHALL be flagged when a and b have different signs and raw sign differs from a.
REQ-028 With sat_en=1 and overflow, the element SHALL be 2^(DW-1)-1 if a is non-negative, else -2^(DW-1).
REQ-029 With sat_en=0, the element SHALL be the raw wrapped value.
REQ-030 The ovf_mask bit SHALL be set on overflow regardless of sat_en.
REQ-031 overflow SHALL equal OR(ovf_mask), updated in the same edge as the mask.
REQ-032 result_out, ovf_mask and overflow SHALL hold stable after done until the next accepted start.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, beat counter 0, busy=0, done=0, result_out=0, ovf_mask=0, overflow=0, and latched operands to 0.
REQ-034 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave per REQ-017.

Verification (DW=8, N=5, LANES=5)
REQ-035 Add, no overflow: all A=3, all B=4, op=0, start at E0 -> all elements 0x07, ovf_mask=0, overflow=0, done high only in the E5 to E6 cycle.
REQ-036 Sub, wrap: A[0]=0x80, B[0]=0x01, others 0, op=1, sat_en=0 -> element0=0x7F, ovf_mask=25'h0000001, overflow=1.
REQ-037 Sub, saturate: same stimulus with sat_en=1 -> element0=0x80, ovf_mask bit0=1, others 0x00.
REQ-038 Add, saturate, last group: A[24]=B[24]=100, op=0, sat_en=1 -> element24=0x7F written at E5, ovf_mask bit24=1; A[23]=-100, B[23]=-100 -> element23=0x80, bit23=1.
REQ-039 Protocol: second start at E2 with different operands -> ignored and results match the first operation; rst_n low at E3 -> all outputs 0 immediately, busy=0, and no done pulse follows.
